// File: rtl/fft_8point_ctrl_if.sv
// Handshake and address bus between the 8-point FFT sequencing controller
// and its neighbours (upstream source, datapath store, downstream sink).
interface fft_8point_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic       bf_en;
  logic [2:0] bf_addr_a;
  logic [2:0] bf_addr_b;
  logic [1:0] tw_idx;
  logic [1:0] stage;
  logic [2:0] rd_addr;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       busy;
  logic       done;

  modport master (
    input  in_valid, out_ready,
    output in_ready, wr_en, wr_addr, bf_en, bf_addr_a, bf_addr_b, tw_idx,
           stage, rd_addr, out_valid, out_last, busy, done
  );

  modport slave (
    output in_valid, out_ready,
    input  in_ready, wr_en, wr_addr, bf_en, bf_addr_a, bf_addr_b, tw_idx,
           stage, rd_addr, out_valid, out_last, busy, done
  );
endinterface

// File: rtl/fft_8point_ctrl.sv
// Sequencer for an 8-point radix-2 DIT FFT: bit-reversed load, 3x4 butterfly
// schedule with twiddle indices, then natural-order unload. One frame at a time.
module fft_8point_ctrl (
  input  logic              clk,
  input  logic              clear,
  fft_8point_ctrl_if.master bus
);
  localparam int N     = 8;
  localparam int LOG2N = 3;

  localparam logic [1:0] S_LOAD   = 2'd0;
  localparam logic [1:0] S_CALC   = 2'd1;
  localparam logic [1:0] S_UNLOAD = 2'd2;

  localparam logic [3:0] LAST_SMP = 4'(N - 1);
  localparam logic [3:0] LAST_BF  = 4'(LOG2N * (N / 2) - 1);

  logic [1:0]       r_state;
  logic [3:0]       r_cnt;
  logic             r_done;

  logic             w_load;
  logic             w_calc;
  logic             w_unload;
  logic             w_hs_in;
  logic             w_hs_out;
  logic [1:0]       w_s;
  logic [1:0]       w_k;
  logic [LOG2N-1:0] w_addr_a;

  function automatic logic [LOG2N-1:0] bitrev3(input logic [LOG2N-1:0] i);
    return {i[0], i[1], i[2]};
  endfunction

  // Upper operand: start of the butterfly's group (groups are 2h wide) plus offset.
  function automatic logic [LOG2N-1:0] upper_addr(input logic [1:0] s, input logic [1:0] k);
    logic [2:0] h, pos, grp;
    h   = 3'd1 << s;
    pos = {1'b0, k} & (h - 3'd1);
    grp = {1'b0, k} >> s;
    return (grp << (s + 2'd1)) + pos;
  endfunction

  function automatic logic [1:0] twiddle(input logic [1:0] s, input logic [1:0] k);
    logic [2:0] h, pos, t;
    h   = 3'd1 << s;
    pos = {1'b0, k} & (h - 3'd1);
    t   = pos << (2'd2 - s);
    return t[1:0];
  endfunction

  assign w_load   = (r_state == S_LOAD);
  assign w_calc   = (r_state == S_CALC);
  assign w_unload = (r_state == S_UNLOAD);
  assign w_s      = r_cnt[3:2];
  assign w_k      = r_cnt[1:0];
  assign w_addr_a = upper_addr(w_s, w_k);

  assign bus.in_ready  = w_load & ~clear;
  assign w_hs_in       = bus.in_valid & bus.in_ready;
  assign w_hs_out      = w_unload & bus.out_ready;

  assign bus.wr_en     = w_hs_in;
  assign bus.wr_addr   = w_load ? bitrev3(r_cnt[2:0]) : 3'd0;
  assign bus.bf_en     = w_calc;
  assign bus.bf_addr_a = w_calc ? w_addr_a : 3'd0;
  assign bus.bf_addr_b = w_calc ? (w_addr_a + (3'd1 << w_s)) : 3'd0;
  assign bus.tw_idx    = w_calc ? twiddle(w_s, w_k) : 2'd0;
  assign bus.stage     = w_calc ? w_s : 2'd0;
  assign bus.rd_addr   = w_unload ? r_cnt[2:0] : 3'd0;
  assign bus.out_valid = w_unload;
  assign bus.out_last  = w_unload & (r_cnt == LAST_SMP);
  assign bus.busy      = w_calc | w_unload;
  assign bus.done      = r_done;

  // The counter restarts from zero at every state change.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_state <= S_LOAD;
      r_cnt   <= 4'd0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_LOAD: begin
          if (w_hs_in) begin
            if (r_cnt == LAST_SMP) begin
              r_state <= S_CALC;
              r_cnt   <= 4'd0;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
        end
        S_CALC: begin
          if (r_cnt == LAST_BF) begin
            r_state <= S_UNLOAD;
            r_cnt   <= 4'd0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_UNLOAD: begin
          if (w_hs_out) begin
            if (r_cnt == LAST_SMP) begin
              r_state <= S_LOAD;
              r_cnt   <= 4'd0;
              r_done  <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
        end
        default: begin
          r_state <= S_LOAD;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fft_8point_ctrl.sv
// Self-checking bench for fft_8point_ctrl with a loop-based FFT schedule model.
module tb_fft_8point_ctrl;
  logic clk = 1'b0;
  logic clear = 1'b1;
  int   cycle = 0;
  int   errors = 0;
  int   checks = 0;

  int exp_wr[8];
  int exp_a[12], exp_b[12], exp_tw[12], exp_st[12];

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  fft_8point_ctrl_if bus();

  fft_8point_ctrl dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  // Schedule from the textbook DIT loop nest: span h, groups of 2h, twiddle j*N/(2h).
  function automatic void build_model();
    int n = 0;
    for (int i = 0; i < 8; i++) begin
      int r = 0;
      for (int b = 0; b < 3; b++) if ((i & (1 << b)) != 0) r = r | (1 << (2 - b));
      exp_wr[i] = r;
    end
    for (int s = 0; s < 3; s++) begin
      int h = 1 << s;
      for (int g = 0; g < 8; g += 2 * h)
        for (int j = 0; j < h; j++) begin
          exp_a[n]  = g + j;
          exp_b[n]  = g + j + h;
          exp_tw[n] = j * (8 / (2 * h));
          exp_st[n] = s;
          n++;
        end
    end
  endfunction

  // pv/pr: percent chance of in_valid/out_ready; pv<0 toggles in_valid, pr<0 stalls 3 cycles at rd_addr 2.
  task automatic run_frame(input int pv, input int pr, input bit after_done,
                           output int t_first, output int stalls);
    int wi = 0, ui = 0, n = 0, cap = -1, idx;
    bit exp_rdy, exp_bf, exp_ov, exp_busy;
    t_first = -1;
    stalls  = 0;
    while (ui < 8 && n < 600) begin
      @(posedge clk); #1;
      if (pv < 0) bus.in_valid = (n % 2 == 0);
      else        bus.in_valid = ($urandom_range(0, 99) < pv);
      if (pr < 0) begin
        bus.out_ready = !(ui == 2 && stalls < 3);
        if (!bus.out_ready) stalls++;
      end else begin
        bus.out_ready = ($urandom_range(0, 99) < pr);
      end
      #1;
      exp_rdy = (wi < 8);
      checks++;
      if (bus.in_ready !== exp_rdy) begin
        errors++; $display("FAIL in_ready n=%0d: got %b want %b", n, bus.in_ready, exp_rdy);
      end
      checks++;
      if (bus.wr_en !== (exp_rdy && bus.in_valid)) begin
        errors++; $display("FAIL wr_en n=%0d: got %b want %b", n, bus.wr_en, exp_rdy && bus.in_valid);
      end
      checks++;
      if (bus.done !== (after_done && n == 0)) begin
        errors++; $display("FAIL done n=%0d: got %b want %b", n, bus.done, after_done && n == 0);
      end
      if (wi < 8 && bus.wr_en === 1'b1) begin
        checks++;
        if (bus.wr_addr !== 3'(exp_wr[wi])) begin
          errors++; $display("FAIL wr_addr #%0d: got %0d want %0d", wi, bus.wr_addr, exp_wr[wi]);
        end
        if (wi == 0) t_first = cycle;
        wi++;
        if (wi == 8) cap = n;
      end else if (wi == 8) begin
        checks++;
        if (bus.wr_addr !== 3'd0) begin
          errors++; $display("FAIL wr_addr_idle: got %0d want 0", bus.wr_addr);
        end
      end
      exp_bf   = (cap >= 0 && n > cap && n <= cap + 12);
      exp_ov   = (cap >= 0 && n > cap + 12);
      exp_busy = (cap >= 0 && n > cap);
      checks++;
      if (bus.bf_en !== exp_bf) begin
        errors++; $display("FAIL bf_en n=%0d: got %b want %b", n, bus.bf_en, exp_bf);
      end
      checks++;
      if (bus.busy !== exp_busy) begin
        errors++; $display("FAIL busy n=%0d: got %b want %b", n, bus.busy, exp_busy);
      end
      checks++;
      if (bus.out_valid !== exp_ov) begin
        errors++; $display("FAIL out_valid n=%0d: got %b want %b", n, bus.out_valid, exp_ov);
      end
      if (exp_bf) begin
        idx = n - cap - 1;
        checks++;
        if (bus.bf_addr_a !== 3'(exp_a[idx]) || bus.bf_addr_b !== 3'(exp_b[idx]) ||
            bus.tw_idx !== 2'(exp_tw[idx]) || bus.stage !== 2'(exp_st[idx])) begin
          errors++;
          $display("FAIL butterfly #%0d: got a=%0d b=%0d tw=%0d st=%0d want a=%0d b=%0d tw=%0d st=%0d",
                   idx, bus.bf_addr_a, bus.bf_addr_b, bus.tw_idx, bus.stage,
                   exp_a[idx], exp_b[idx], exp_tw[idx], exp_st[idx]);
        end
      end else begin
        checks++;
        if ({bus.bf_addr_a, bus.bf_addr_b, bus.tw_idx, bus.stage} !== 10'd0) begin
          errors++; $display("FAIL bf_idle n=%0d: got a=%0d b=%0d tw=%0d st=%0d want 0",
                             n, bus.bf_addr_a, bus.bf_addr_b, bus.tw_idx, bus.stage);
        end
      end
      if (exp_ov) begin
        checks++;
        if (bus.rd_addr !== 3'(ui) || bus.out_last !== (ui == 7)) begin
          errors++; $display("FAIL unload #%0d: got rd=%0d last=%b want rd=%0d last=%b",
                             ui, bus.rd_addr, bus.out_last, ui, ui == 7);
        end
        if (bus.out_ready) ui++;
      end else begin
        checks++;
        if (bus.rd_addr !== 3'd0 || bus.out_last !== 1'b0) begin
          errors++; $display("FAIL unload_idle n=%0d: got rd=%0d last=%b want 0", n, bus.rd_addr, bus.out_last);
        end
      end
      n++;
    end
    if (ui < 8) begin
      errors++; checks++;
      $display("FAIL frame_timeout: got %0d results want 8", ui);
    end
  endtask

  task automatic post_frame();
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    checks++;
    if (bus.done !== 1'b1 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL done_pulse: got done=%b rdy=%b want 1 1", bus.done, bus.in_ready);
    end
    @(posedge clk); #2;
    checks++;
    if (bus.done !== 1'b0) begin
      errors++; $display("FAIL done_width: got %b want 0", bus.done);
    end
  endtask

  task automatic release_clear();
    @(posedge clk); #1;
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL in_ready_after_clear: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if ({bus.in_ready, bus.wr_en, bus.bf_en, bus.out_valid, bus.out_last, bus.busy, bus.done} !== 7'd0 ||
        {bus.wr_addr, bus.bf_addr_a, bus.bf_addr_b, bus.tw_idx, bus.stage, bus.rd_addr} !== 16'd0) begin
      errors++; $display("FAIL reset_state: got rdy=%b bf=%b ov=%b busy=%b done=%b want all 0",
                         bus.in_ready, bus.bf_en, bus.out_valid, bus.busy, bus.done);
    end
    release_clear();
  endtask

  // Streams samples continuously for k edges, then aborts with clear.
  task automatic test_abort(input int k);
    int tf, st;
    bit exp_busy;
    @(posedge clk); #1;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    repeat (k) @(posedge clk);
    #1;
    exp_busy = (k >= 8);
    checks++;
    if (bus.busy !== exp_busy || bus.bf_en !== (k >= 8 && k < 20) || bus.out_valid !== (k >= 20)) begin
      errors++; $display("FAIL abort_pre k=%0d: got busy=%b bf=%b ov=%b want %b %b %b", k,
                         bus.busy, bus.bf_en, bus.out_valid, exp_busy, k >= 8 && k < 20, k >= 20);
    end
    clear = 1'b1;
    #1;
    checks++;
    if ({bus.bf_en, bus.busy, bus.out_valid, bus.in_ready, bus.wr_en} !== 5'd0 ||
        {bus.wr_addr, bus.bf_addr_a, bus.bf_addr_b, bus.rd_addr} !== 12'd0) begin
      errors++; $display("FAIL abort_clear k=%0d: got bf=%b busy=%b ov=%b rdy=%b wr=%b want 0", k,
                         bus.bf_en, bus.busy, bus.out_valid, bus.in_ready, bus.wr_en);
    end
    release_clear();
    run_frame(100, 100, 1'b0, tf, st);
    post_frame();
  endtask

  task automatic test_load_order();
    int tf, st;
    run_frame(100, 100, 1'b0, tf, st);
    post_frame();
  endtask

  task automatic test_random_frames();
    int tf, st;
    for (int f = 0; f < 4; f++) begin
      run_frame(60, 55, 1'b0, tf, st);
      post_frame();
    end
  endtask

  task automatic test_unload_backpressure();
    int tf, st;
    run_frame(100, -1, 1'b0, tf, st);
    checks++;
    if (st !== 3) begin
      errors++; $display("FAIL stall_cycles: got %0d want 3", st);
    end
    post_frame();
  endtask

  task automatic test_gapped_input();
    int tf, st;
    run_frame(-1, 100, 1'b0, tf, st);
    post_frame();
  endtask

  task automatic test_back_to_back();
    int t1, t2, t3, st;
    run_frame(100, 100, 1'b0, t1, st);
    run_frame(100, 100, 1'b1, t2, st);
    run_frame(100, 100, 1'b1, t3, st);
    checks++;
    if (t2 - t1 !== 28 || t3 - t2 !== 28) begin
      errors++; $display("FAIL frame_period: got %0d %0d want 28 28", t2 - t1, t3 - t2);
    end
    post_frame();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    build_model();
    test_reset();
    test_load_order();
    test_unload_backpressure();
    test_gapped_input();
    test_back_to_back();
    test_random_frames();
    test_abort(3);
    test_abort(12);
    test_abort(24);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
